// File: rtl/wh_profiler_pkg.sv
// Shared profiler definitions: sequencer FSM states and the auto-sample tag value.
// Latency: none, types and constants only.
// Backpressure: none, no handshake lives here.
package wh_profiler_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        GAP  = 2'd2
    } seq_state_e;

    // All-ones tag marks an auto-sample strobe; users slice it to their tag width.
    localparam int auto_tag_max_width_c = 256;
    localparam logic [auto_tag_max_width_c-1:0] auto_tag_c = '1;

endpackage

// File: rtl/wh_link_stat_sequencer_if.sv
// Request/strobe bundle of the link-stat sequencer: requester drives tags, profiler side gets strobes.
// Latency: wires only.
// Backpressure: req_ready qualifies req_v; print_stat_v is a strobe with no return path.
interface wh_link_stat_sequencer_if #(
    parameter int data_width_p = 32
);
    logic                    req_v;
    logic [data_width_p-1:0] req_tag;
    logic                    req_ready;
    logic                    print_stat_v;
    logic [data_width_p-1:0] print_stat_tag;

    modport master (
        output req_v,
        output req_tag,
        input  req_ready,
        input  print_stat_v,
        input  print_stat_tag
    );

    modport slave (
        input  req_v,
        input  req_tag,
        output req_ready,
        output print_stat_v,
        output print_stat_tag
    );
endinterface

// File: rtl/bsg_fifo_1r1w_small.sv
// Small one-read one-write FIFO with a combinational head (data_o valid whenever v_o is high).
// Latency: a word written in cycle t is visible at the head in cycle t+1.
// Backpressure: ready_o low when full; yumi_i pops the head and may coincide with a write.
module bsg_fifo_1r1w_small #(
    parameter int width_p = 32,
    parameter int els_p   = 4
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               v_i,
    output logic               ready_o,
    input  logic [width_p-1:0] data_i,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    input  logic               yumi_i
);
    localparam int ptr_w_lp = $clog2(els_p);

    // Pointers carry one wrap bit so full and empty are distinguishable.
    logic [ptr_w_lp:0]    wptr_r, rptr_r;
    logic [width_p-1:0]   mem_r [els_p];
    logic                 enq, deq;

    assign v_o     = (wptr_r != rptr_r);
    assign ready_o = !((wptr_r[ptr_w_lp] != rptr_r[ptr_w_lp]) &&
                       (wptr_r[ptr_w_lp-1:0] == rptr_r[ptr_w_lp-1:0]));
    assign data_o  = mem_r[rptr_r[ptr_w_lp-1:0]];
    assign enq     = v_i & ready_o;
    assign deq     = yumi_i & v_o;

    // Pointer update; reset empties the queue.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            wptr_r <= '0;
            rptr_r <= '0;
        end else begin
            if (enq) wptr_r <= wptr_r + (ptr_w_lp+1)'(1);
            if (deq) rptr_r <= rptr_r + (ptr_w_lp+1)'(1);
        end
    end

    // Storage needs no reset: entries are only read while valid.
    always_ff @(posedge clk_i) begin
        if (enq) mem_r[wptr_r[ptr_w_lp-1:0]] <= data_i;
    end
endmodule

// File: rtl/wh_link_stat_sequencer.sv
// Queues print-stat tags (plus periodic auto-samples when WH_LINK_STAT_SEQ_PERIODIC_EN is defined) and emits one-cycle strobes min_gap_p idle cycles apart.
// Latency: a request accepted into an empty queue while idle and enabled strobes two cycles later.
// Backpressure: req_ready_o drops while the tag queue is full; en_i low stops strobes but requests still queue.
module wh_link_stat_sequencer
    import wh_profiler_pkg::*;
#(
    parameter int data_width_p   = 32,
    parameter int queue_els_p    = 4,
    parameter int min_gap_p      = 8,
    parameter int period_width_p = 24
) (
    input  logic                      clk_i,
    input  logic                      reset_n_i,
    input  logic                      en_i,
    input  logic                      req_v_i,
    input  logic [data_width_p-1:0]   req_tag_i,
    output logic                      req_ready_o,
    input  logic [period_width_p-1:0] period_i,
    output logic [31:0]               global_ctr_o,
    output logic                      print_stat_v_o,
    output logic [data_width_p-1:0]   print_stat_tag_o,
    output logic [15:0]               overrun_o
);
    localparam int gap_w_lp = (min_gap_p > 1) ? $clog2(min_gap_p) : 1;
    localparam logic [gap_w_lp-1:0]     gap_last_lp = gap_w_lp'(min_gap_p - 1);
    localparam logic [data_width_p-1:0] auto_tag_lp = auto_tag_c[data_width_p-1:0];

    seq_state_e                state_r, state_n;
    logic [gap_w_lp-1:0]       gap_cnt_r, gap_cnt_n;
    logic [31:0]               global_ctr_r;
    logic                      print_v_r;
    logic [data_width_p-1:0]   print_tag_r, print_tag_n;
    logic                      fifo_v, fifo_yumi;
    logic [data_width_p-1:0]   fifo_data;
    logic                      launch, take_auto;
    logic                      auto_pending_r;
    logic [15:0]               overrun_r;

    bsg_fifo_1r1w_small #(
        .width_p (data_width_p),
        .els_p   (queue_els_p)
    ) tag_fifo (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .v_i       (req_v_i),
        .ready_o   (req_ready_o),
        .data_i    (req_tag_i),
        .v_o       (fifo_v),
        .data_o    (fifo_data),
        .yumi_i    (fifo_yumi)
    );

    // Free-running cycle count used by the profiler as its timestamp.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) global_ctr_r <= '0;
        else            global_ctr_r <= global_ctr_r + 32'd1;
    end

    // State, gap timer and the registered strobe/tag outputs.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_r     <= IDLE;
            gap_cnt_r   <= '0;
            print_v_r   <= 1'b0;
            print_tag_r <= '0;
        end else begin
            state_r     <= state_n;
            gap_cnt_r   <= gap_cnt_n;
            print_v_r   <= (state_n == EMIT);
            print_tag_r <= print_tag_n;
        end
    end

    // Next state: the last GAP cycle also makes the IDLE decision, so back-to-back
    // strobes land exactly min_gap_p+1 cycles apart. Queued tags beat auto-samples.
    always_comb begin
        state_n     = state_r;
        gap_cnt_n   = gap_cnt_r;
        print_tag_n = print_tag_r;
        launch      = 1'b0;
        fifo_yumi   = 1'b0;
        take_auto   = 1'b0;
        case (state_r)
            IDLE: launch = en_i & (fifo_v | auto_pending_r);
            EMIT: begin
                state_n   = GAP;
                gap_cnt_n = '0;
            end
            GAP: begin
                if (gap_cnt_r == gap_last_lp) begin
                    state_n = IDLE;
                    launch  = en_i & (fifo_v | auto_pending_r);
                end else begin
                    gap_cnt_n = gap_cnt_r + gap_w_lp'(1);
                end
            end
            default: state_n = IDLE;
        endcase
        if (launch) begin
            state_n     = EMIT;
            fifo_yumi   = fifo_v;
            take_auto   = ~fifo_v;
            print_tag_n = fifo_v ? fifo_data : auto_tag_lp;
        end
    end

`ifdef WH_LINK_STAT_SEQ_PERIODIC_EN
    logic [period_width_p-1:0] period_cnt_r;
    logic                      tick;

    assign tick = (period_i != '0) && (period_cnt_r >= period_i - period_width_p'(1));

    // Period counter, single-entry auto-sample pending flag and saturating drop count.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            period_cnt_r   <= '0;
            auto_pending_r <= 1'b0;
            overrun_r      <= '0;
        end else begin
            if ((period_i == '0) || tick) period_cnt_r <= '0;
            else                          period_cnt_r <= period_cnt_r + period_width_p'(1);
            auto_pending_r <= (auto_pending_r & ~take_auto) | tick;
            if (tick && auto_pending_r && !take_auto && (overrun_r != 16'hFFFF))
                overrun_r <= overrun_r + 16'd1;
        end
    end
`else
    logic unused_periodic;

    assign auto_pending_r  = 1'b0;
    assign overrun_r       = '0;
    assign unused_periodic = ^{period_i, take_auto};
`endif

    assign global_ctr_o     = global_ctr_r;
    assign print_stat_v_o   = print_v_r;
    assign print_stat_tag_o = print_tag_r;
    assign overrun_o        = overrun_r;
endmodule

// File: tb/tb_wh_link_stat_sequencer.sv
// Scoreboard bench for wh_link_stat_sequencer: directed scenarios then randomized traffic against a reference model.
// Latency: checks strobes at the exact cycle the model predicts.
// Backpressure: model decides acceptance from its own queue occupancy.
module tb_wh_link_stat_sequencer;
    localparam int DW = 32;
    localparam int QE = 4;
    localparam int MG = 8;
    localparam int PW = 24;

    typedef struct {
        logic [DW-1:0] tag;
        int            cyc;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en;
    logic [PW-1:0] period;
    logic [31:0]   gctr;
    logic [15:0]   ovr;

    wh_link_stat_sequencer_if #(.data_width_p(DW)) lnk ();

    always #5 clk = ~clk;

    wh_link_stat_sequencer #(
        .data_width_p   (DW),
        .queue_els_p    (QE),
        .min_gap_p      (MG),
        .period_width_p (PW)
    ) dut (
        .clk_i            (clk),
        .reset_n_i        (rst_n),
        .en_i             (en),
        .req_v_i          (lnk.req_v),
        .req_tag_i        (lnk.req_tag),
        .req_ready_o      (lnk.req_ready),
        .period_i         (period),
        .global_ctr_o     (gctr),
        .print_stat_v_o   (lnk.print_stat_v),
        .print_stat_tag_o (lnk.print_stat_tag),
        .overrun_o        (ovr)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit model_on = 1'b0;

    exp_t          exp_q[$];
    int            log_cyc[$];
    logic [DW-1:0] log_tag[$];

    // Reference model state: values seen during the current cycle.
    logic [DW-1:0] m_q[$];
    bit            m_pend;
    int            m_pcnt;
    int            m_ovr;
    logic [31:0]   m_gctr;
    int            m_last;
    bit            m_rdy, m_work, m_take, m_tick;
    exp_t          m_e, mon_e;
    logic [DW-1:0] ones = '1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        lnk.req_v = 1'b0;
        step(2);
        rst_n = 1'b1;
    endtask

    // Reference model: at each edge, apply the rules to the cycle that just ended.
    initial forever begin
        @(posedge clk);
        cyc++;
        if (!rst_n) begin
            m_q.delete();
            m_pend   = 1'b0;
            m_pcnt   = 0;
            m_ovr    = 0;
            m_gctr   = '0;
            m_last   = -1000;
            model_on = 1'b1;
        end else begin
            m_rdy  = (m_q.size() < QE);
            m_work = (m_q.size() > 0) || m_pend;
            m_take = 1'b0;
            m_tick = 1'b0;
            if (en && m_work && ((cyc - 1) >= m_last + MG)) begin
                if (m_q.size() > 0) begin
                    m_e.tag = m_q.pop_front();
                end else begin
                    m_e.tag = ones;
                    m_take  = 1'b1;
                end
                m_e.cyc = cyc;
                exp_q.push_back(m_e);
                m_last = cyc;
            end
            if (lnk.req_v && m_rdy) m_q.push_back(lnk.req_tag);
`ifdef WH_LINK_STAT_SEQ_PERIODIC_EN
            m_tick = (period != '0) && (m_pcnt >= int'(period) - 1);
            if ((period == '0) || m_tick) m_pcnt = 0;
            else                          m_pcnt++;
            if (m_tick) begin
                if (m_pend && !m_take && (m_ovr < 65535)) m_ovr++;
                m_pend = 1'b1;
            end else if (m_take) begin
                m_pend = 1'b0;
            end
`endif
            m_gctr = m_gctr + 32'd1;
        end
    end

    // Monitor: compare strobes against the scoreboard and steady outputs against the model.
    initial forever begin
        @(negedge clk);
        if (model_on) begin
            while ((exp_q.size() > 0) && (exp_q[0].cyc < cyc)) begin
                mon_e = exp_q.pop_front();
                checks++;
                errors++;
                $display("FAIL strobe_missing: none at cycle %0d, expected tag %0h", mon_e.cyc, mon_e.tag);
            end
            if (lnk.print_stat_v) begin
                log_cyc.push_back(cyc);
                log_tag.push_back(lnk.print_stat_tag);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL strobe_unexpected: tag %0h at cycle %0d, expected none", lnk.print_stat_tag, cyc);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("strobe_cycle", 64'(cyc), 64'(mon_e.cyc));
                    chk("strobe_tag", 64'(lnk.print_stat_tag), 64'(mon_e.tag));
                end
            end
            chk("req_ready", 64'(lnk.req_ready), 64'(m_q.size() < QE));
            chk("global_ctr", 64'(gctr), 64'(m_gctr));
            chk("overrun", 64'(ovr), 64'(m_ovr));
        end
    end

    initial begin
        int t;
        int acc;
        lnk.req_v   = 1'b0;
        lnk.req_tag = '0;
        rst_n       = 1'b0;
        en          = 1'b0;
        period      = '0;
        do_reset();

        // Reset then idle: counter counts, no strobes, tag cleared.
        log_cyc.delete(); log_tag.delete();
        step(10);
        chk("idle_gctr", 64'(gctr), 64'd10);
        chk("idle_no_strobe", 64'(log_cyc.size()), 64'd0);
        chk("reset_tag", 64'(lnk.print_stat_tag), 64'd0);

        // Single request: strobe two cycles after acceptance.
        en = 1'b1;
        lnk.req_v = 1'b1; lnk.req_tag = 32'd5; t = cyc;
        step(1);
        lnk.req_v = 1'b0;
        step(12);
        chk("single_count", 64'(log_cyc.size()), 64'd1);
        if (log_cyc.size() >= 1) begin
            chk("single_cycle", 64'(log_cyc[0]), 64'(t + 2));
            chk("single_tag", 64'(log_tag[0]), 64'd5);
        end

        // Fill while disabled: only QE accepted, then in-order strobes MG+1 apart.
        en = 1'b0; acc = 0;
        log_cyc.delete(); log_tag.delete();
        for (int i = 0; i < 6; i++) begin
            lnk.req_v = 1'b1; lnk.req_tag = 32'(100 + i);
            acc += int'(lnk.req_ready);
            step(1);
        end
        lnk.req_v = 1'b0;
        chk("full_accepted", 64'(acc), 64'd4);
        chk("full_ready_low", 64'(lnk.req_ready), 64'd0);
        step(3);
        chk("disabled_no_strobe", 64'(log_cyc.size()), 64'd0);
        en = 1'b1;
        step(50);
        chk("full_count", 64'(log_cyc.size()), 64'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < log_cyc.size()) begin
                chk("full_order", 64'(log_tag[i]), 64'(100 + i));
                if (i > 0) chk("full_spacing", 64'(log_cyc[i] - log_cyc[i-1]), 64'(MG + 1));
            end
        end

        // Reset mid-GAP with three queued: nothing further, counter restarts.
        log_cyc.delete(); log_tag.delete();
        for (int i = 0; i < 4; i++) begin
            lnk.req_v = 1'b1; lnk.req_tag = 32'(200 + i);
            step(1);
        end
        lnk.req_v = 1'b0;
        step(2);
        do_reset();
        step(5);
        chk("rst_gctr_restart", 64'(gctr), 64'd5);
        chk("rst_ready", 64'(lnk.req_ready), 64'd1);
        step(40);
        chk("rst_strobes", 64'(log_cyc.size()), 64'd1);
        if (log_cyc.size() >= 1) chk("rst_first_tag", 64'(log_tag[0]), 64'd200);

`ifdef WH_LINK_STAT_SEQ_PERIODIC_EN
        // Tick and request in the same idle cycle: request first, auto-sample MG+1 later.
        do_reset();
        en = 1'b1; period = '0;
        step(3);
        log_cyc.delete(); log_tag.delete();
        period = 24'd20; t = cyc;
        step(19);
        lnk.req_v = 1'b1; lnk.req_tag = 32'd77;
        step(1);
        lnk.req_v = 1'b0;
        step(20);
        chk("prio_count", 64'(log_cyc.size()), 64'd2);
        if (log_cyc.size() >= 2) begin
            chk("prio_req_tag", 64'(log_tag[0]), 64'd77);
            chk("prio_req_cycle", 64'(log_cyc[0]), 64'(t + 21));
            chk("prio_auto_tag", 64'(log_tag[1]), 64'(ones));
            chk("prio_auto_cycle", 64'(log_cyc[1]), 64'(t + 30));
        end

        // Periodic strobes every 20 cycles, then drops counted while disabled.
        log_cyc.delete(); log_tag.delete();
        step(60);
        chk("auto_count", 64'(log_cyc.size()), 64'd3);
        for (int i = 0; i < log_cyc.size(); i++) begin
            chk("auto_tag", 64'(log_tag[i]), 64'(ones));
            if (i > 0) chk("auto_period", 64'(log_cyc[i] - log_cyc[i-1]), 64'd20);
        end
        for (int i = 0; (i < 40) && (log_cyc.size() < 4); i++) step(1);
        chk("auto_strobe_seen", 64'(log_cyc.size()), 64'd4);
        en = 1'b0;
        step(100);
        chk("overrun_after_100", 64'(ovr), 64'd4);
        period = '0; en = 1'b1;
        step(15);
`endif

        // Randomized traffic, enable toggling, occasional resets.
        for (int i = 0; i < 2500; i++) begin
            lnk.req_v   = ($urandom_range(0, 99) < 40);
            lnk.req_tag = $urandom();
            if ($urandom_range(0, 99) < 6) en = ($urandom_range(0, 99) < 75);
            rst_n = ($urandom_range(0, 399) != 0);
`ifdef WH_LINK_STAT_SEQ_PERIODIC_EN
            if ($urandom_range(0, 149) == 0) period = PW'($urandom_range(0, 30));
`endif
            step(1);
        end

        // Drain and confirm every predicted strobe appeared.
        lnk.req_v = 1'b0; rst_n = 1'b1; en = 1'b1; period = '0;
        step(60);
        chk("drain_empty", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/wh_link_stat_sequencer.md
WH_LINK_STAT_SEQUENCER -- requirements
Module: wh_link_stat_sequencer

Interface
REQ-001 SHALL have parameter data_width_p, default 32, width of stat tags.
REQ-002 SHALL have parameter queue_els_p, default 4, depth of the request tag queue (power of 2, >=2).
REQ-003 SHALL have parameter min_gap_p, default 8, minimum idle cycles between two print strobes (>=1).
REQ-004 SHALL have parameter period_width_p, default 24, width of the auto-sample period input.
REQ-005 SHALL have port clk_i input 1: the single clock, all state on its rising edge.
REQ-006 SHALL have port reset_n_i input 1: synchronous, active-low reset.
REQ-007 SHALL have port en_i input 1: enables issuing print strobes; requests are still queued while low.
REQ-008 SHALL have port req_v_i input 1: print-stat request valid.
REQ-009 SHALL have port req_tag_i input data_width_p: tag carried by the request.
REQ-010 SHALL have port req_ready_o output 1: request accepted when req_v_i & req_ready_o.
REQ-011 SHALL have port period_i input period_width_p: auto-sample period in cycles; 0 disables.
REQ-012 SHALL have port global_ctr_o output 32: free-running cycle count, fed to the link profiler.
REQ-013 SHALL have port print_stat_v_o output 1: one-cycle print strobe to the link profiler.
REQ-014 SHALL have port print_stat_tag_o output data_width_p: tag qualified by print_stat_v_o.
REQ-015 SHALL have port overrun_o output 16: saturating count of auto-sample ticks dropped.

Function
REQ-016 SHALL increment global_ctr_o by 1 every cycle out of reset and wrap 32'hFFFF_FFFF -> 0.
REQ-017 SHALL drive req_ready_o = queue not full; with queue full, req_v_i is ignored and not lost silently at the source (no acceptance).
REQ-018 SHALL implement FSM IDLE, EMIT, GAP: IDLE->EMIT when en_i and (queue non-empty or auto pending); EMIT lasts exactly 1 cycle then ->GAP; GAP lasts min_gap_p cycles then ->IDLE.
REQ-019 SHALL assert print_stat_v_o only in EMIT, with registered output; a request accepted in cycle t into an empty queue with FSM in IDLE and en_i high SHALL strobe in cycle t+2.
REQ-020 SHALL give queued requests priority over an auto-sample; the auto-sample stays pending and is issued at the next IDLE.
REQ-021 SHALL use tag {data_width_p{1'b1}} (package constant) for auto-sample strobes.
REQ-022 SHALL run a period counter while period_i != 0: tick when counter >= period_i-1, then counter -> 0; period_i == 0 holds counter at 0.
REQ-023 SHALL set a 1-bit auto-pending flag on tick; a tick while already pending SHALL increment overrun_o, saturating at 16'hFFFF.
REQ-024 SHALL on simultaneous accept and dequeue in one cycle keep occupancy unchanged, including when full (ready low means no accept).
REQ-025 SHALL, when en_i drops mid-GAP, finish GAP and hold in IDLE; queue contents and pending flag are retained.

Reset
REQ-026 SHALL on reset_n_i low set: global_ctr_o=0, print_stat_v_o=0, print_stat_tag_o=0, overrun_o=0, queue empty, req_ready_o=1 in the following cycle, FSM=IDLE, pending=0, counters=0.
REQ-027 SHALL abort any EMIT/GAP in progress and discard queued tags when reset asserts mid-operation.

Configuration
REQ-028 SHALL compile auto-sampling only when WH_LINK_STAT_SEQ_PERIODIC_EN is defined; otherwise period_i is ignored, no auto strobes occur, overrun_o is tied 0.

Structure
REQ-029 SHALL place the FSM state enum and the auto-sample tag constant in shared package wh_profiler_pkg.
REQ-030 SHALL instantiate bsg_fifo_1r1w_small as the tag queue sub-module.

Verification
REQ-031 SHALL verify: reset then idle 10 cycles -> global_ctr_o=10, print_stat_v_o never high.
REQ-032 SHALL verify: one request tag 5 at cycle t, en_i=1 -> single strobe tag 5 at t+2.
REQ-033 SHALL verify: 6 back-to-back requests, queue_els_p=4, en_i=0 -> 4 accepted, req_ready_o=0; set en_i -> 4 strobes spaced min_gap_p+1=9 cycles apart, in order.
REQ-034 SHALL verify (macro on): period_i=20, no requests -> strobes every 20 cycles with all-ones tag; en_i=0 for 100 cycles -> overrun_o=4.
REQ-035 SHALL verify: auto tick and request in same IDLE cycle -> request tag first, auto strobe 9 cycles later.
REQ-036 SHALL verify: reset pulsed during GAP with 3 queued -> no further strobes, queue empty, global_ctr_o restarts at 0.
